// File: rtl/status_capture_pkg.sv
// Shared encodings and helpers for the status capture / output-select block.
package status_capture_pkg;

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_DV   = 2'b01;
  localparam logic [1:0] MODE_VAL  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_t;

  // Increment that sticks at all-ones; w is the meaningful width of v (1..16).
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input int w);
    logic [15:0] top;
    top = 16'((32'd1 << w) - 32'd1);
    return (v == top) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/status_chan.sv
// One channel: live/shadow merge, captured status, sticky change bits, saturating change count.
// Latency: live to state 1 cycle. Backpressure: none; clr is a single-edge strobe from the read port.
module status_chan
  import status_capture_pkg::*;
#(
  parameter int W     = 9,
  parameter int CNT_W = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [W-1:0]     live,
  input  logic [W-1:0]     sel_mask,
  input  logic [W-1:0]     shadow,
  input  logic             clr,
  output logic [W-1:0]     stat_nxt,
  output logic [W-1:0]     sticky_nxt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [W-1:0]     stat_q;
  logic [W-1:0]     sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     chg;
  logic             chg_any;

  // Next-state values are exported so the read port can snapshot the post-edge state.
  always_comb begin
    stat_nxt = (sel_mask & live) | (~sel_mask & shadow);
    chg      = stat_nxt ^ stat_q;
    chg_any  = |chg;
    if (clr) begin
      sticky_nxt = chg;
      cnt_nxt    = CNT_W'(chg_any);
    end else begin
      sticky_nxt = sticky_q | chg;
      cnt_nxt    = chg_any ? CNT_W'(sat_inc(16'(cnt_q), CNT_W)) : cnt_q;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      stat_q   <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      stat_q   <= stat_nxt;
      sticky_q <= sticky_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

endmodule

// File: rtl/status_capture_mux.sv
// Multi-channel status capture with shadow merge, request/ack read port and mode-selected output drive.
// Latency: 1 cycle for status/outputs; rd_ack the cycle after rd_req is taken. Backpressure: none; rd_req ignored during ACK.
module status_capture_mux
  import status_capture_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int W     = 9,
  parameter  int CNT_W = 8,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [CH*W-1:0]   live,
  input  logic [W-1:0]      sel_mask,
  input  logic              shadow_wr,
  input  logic [CHW-1:0]    shadow_ch,
  input  logic [W-1:0]      shadow_wdata,
  input  logic [1:0]        mode,
  input  logic [CH-1:0]     aux,
  input  logic [CH-1:0]     outy,
  input  logic [CH-1:0]     dv,
  input  logic [CH-1:0]     value,
  output logic [CH-1:0]     out_i,
  input  logic              rd_req,
  input  logic [CHW-1:0]    rd_ch,
  output logic              rd_ack,
  output logic [W-1:0]      rd_data,
  output logic [W-1:0]      rd_sticky,
  output logic [CNT_W-1:0]  rd_cnt
);

  rd_state_t        state_q, state_n;
  logic             load_rd;
  logic [CHW-1:0]   rd_ch_q;
  logic [CH-1:0]    clr;
  logic [W-1:0]     stat_nxt   [CH];
  logic [W-1:0]     sticky_nxt [CH];
  logic [CNT_W-1:0] cnt_nxt    [CH];
  logic [W-1:0]     sel_stat;
  logic [W-1:0]     sel_sticky;
  logic [CNT_W-1:0] sel_cnt;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic         wr_en;
    logic [W-1:0] shadow_q;

    // Out-of-range write channels never match any decode, so they drop silently.
    assign wr_en  = shadow_wr && (shadow_ch == CHW'(c));
    assign clr[c] = (state_q == RD_ACK) && (rd_ch_q == CHW'(c));

    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)     shadow_q <= '0;
      else if (wr_en) shadow_q <= shadow_wdata;
    end

    status_chan #(.W(W), .CNT_W(CNT_W)) u_chan (
      .sysclk     (sysclk),
      .reset      (reset),
      .live       (live[c*W +: W]),
      .sel_mask   (sel_mask),
      .shadow     (shadow_q),
      .clr        (clr[c]),
      .stat_nxt   (stat_nxt[c]),
      .sticky_nxt (sticky_nxt[c]),
      .cnt_nxt    (cnt_nxt[c])
    );
  end

  always_comb begin
    sel_stat   = '0;
    sel_sticky = '0;
    sel_cnt    = '0;
    for (int c = 0; c < CH; c++) begin
      if (rd_ch == CHW'(c)) begin
        sel_stat   = stat_nxt[c];
        sel_sticky = sticky_nxt[c];
        sel_cnt    = cnt_nxt[c];
      end
    end
  end

  always_comb begin
    state_n = state_q;
    load_rd = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_req) begin
          state_n = RD_ACK;
          load_rd = 1'b1;
        end
      end
      RD_ACK:  state_n = RD_IDLE;
      default: state_n = RD_IDLE;
    endcase
  end

  assign rd_ack = (state_q == RD_ACK);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q   <= RD_IDLE;
      rd_ch_q   <= '0;
      rd_data   <= '0;
      rd_sticky <= '0;
      rd_cnt    <= '0;
    end else begin
      state_q <= state_n;
      if (load_rd) begin
        rd_ch_q   <= rd_ch;
        rd_data   <= sel_stat;
        rd_sticky <= sel_sticky;
        rd_cnt    <= sel_cnt;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      out_i <= '0;
    end else begin
      case (mode)
        MODE_XOR:  out_i <= aux ^ outy;
        MODE_DV:   out_i <= dv;
        MODE_VAL:  out_i <= value;
        MODE_HOLD: out_i <= out_i;
        default:   out_i <= out_i;
      endcase
    end
  end

endmodule

// File: tb/tb_status_capture_mux.sv
// Randomised and directed bench for status_capture_mux against a cycle-level behavioural model.
module tb_status_capture_mux;
  import status_capture_pkg::*;

  localparam int CH    = 5;
  localparam int W     = 9;
  localparam int CNT_W = 2;
  localparam int CHW   = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              sysclk = 1'b0;
  logic              reset  = 1'b1;
  logic [CH*W-1:0]   live;
  logic [W-1:0]      sel_mask;
  logic              shadow_wr;
  logic [CHW-1:0]    shadow_ch;
  logic [W-1:0]      shadow_wdata;
  logic [1:0]        mode;
  logic [CH-1:0]     aux, outy, dv, value;
  logic [CH-1:0]     out_i;
  logic              rd_req;
  logic [CHW-1:0]    rd_ch;
  logic              rd_ack;
  logic [W-1:0]      rd_data;
  logic [W-1:0]      rd_sticky;
  logic [CNT_W-1:0]  rd_cnt;

  status_capture_mux #(.CH(CH), .W(W), .CNT_W(CNT_W)) dut (
    .sysclk(sysclk), .reset(reset), .live(live), .sel_mask(sel_mask),
    .shadow_wr(shadow_wr), .shadow_ch(shadow_ch), .shadow_wdata(shadow_wdata),
    .mode(mode), .aux(aux), .outy(outy), .dv(dv), .value(value), .out_i(out_i),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_data(rd_data),
    .rd_sticky(rd_sticky), .rd_cnt(rd_cnt)
  );

  always #5 sysclk = ~sysclk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: per-channel status words, sticky words and integer counts.
  logic [W-1:0]  m_shadow [CH];
  logic [W-1:0]  m_stat   [CH];
  logic [W-1:0]  m_sticky [CH];
  int            m_cnt    [CH];
  logic [CH-1:0] m_out;
  bit            m_ack;
  int            m_ch;
  logic [W-1:0]  m_rdata, m_rsticky;
  int            m_rcnt;
  logic [W-1:0]  md, mchg;

  always @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        m_shadow[c] = '0; m_stat[c] = '0; m_sticky[c] = '0; m_cnt[c] = 0;
      end
      m_out = '0; m_ack = 1'b0; m_ch = 0;
      m_rdata = '0; m_rsticky = '0; m_rcnt = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        md   = (sel_mask & live[c*W +: W]) | (~sel_mask & m_shadow[c]);
        mchg = md ^ m_stat[c];
        m_stat[c] = md;
        if (m_ack && m_ch == c) begin
          m_sticky[c] = mchg;
          m_cnt[c]    = (mchg != 0) ? 1 : 0;
        end else begin
          m_sticky[c] = m_sticky[c] | mchg;
          if (mchg != 0 && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
        end
      end
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (rd_req) begin
        m_ack = 1'b1;
        m_ch  = int'(rd_ch);
        if (m_ch < CH) begin
          m_rdata = m_stat[m_ch]; m_rsticky = m_sticky[m_ch]; m_rcnt = m_cnt[m_ch];
        end else begin
          m_rdata = '0; m_rsticky = '0; m_rcnt = 0;
        end
      end
      if (shadow_wr && int'(shadow_ch) < CH) m_shadow[shadow_ch] = shadow_wdata;
      case (mode)
        MODE_XOR: m_out = aux ^ outy;
        MODE_DV:  m_out = dv;
        MODE_VAL: m_out = value;
        default:  m_out = m_out;
      endcase
    end
  end

  always @(negedge sysclk) begin
    if (cmp_en) begin
      check("out_i",     32'(out_i),     32'(m_out));
      check("rd_ack",    32'(rd_ack),    32'(m_ack));
      check("rd_data",   32'(rd_data),   32'(m_rdata));
      check("rd_sticky", 32'(rd_sticky), 32'(m_rsticky));
      check("rd_cnt",    32'(rd_cnt),    32'(m_rcnt));
    end
  end

  // Returns on the negedge of the ack cycle; the following posedge is the clear edge.
  task automatic do_read(input int ch, output logic [W-1:0] d, output logic [W-1:0] s,
                         output logic [CNT_W-1:0] n);
    @(negedge sysclk);
    rd_ch  = CHW'(ch);
    rd_req = 1'b1;
    @(negedge sysclk);
    rd_req = 1'b0;
    check("rd_ack_pulse", 32'(rd_ack), 32'd1);
    d = rd_data; s = rd_sticky; n = rd_cnt;
  endtask

  logic [W-1:0]     rdd, rds;
  logic [CNT_W-1:0] rdn;
  int               acks;

  initial begin
    live = '1; sel_mask = '0; shadow_wr = 1'b0; shadow_ch = '0; shadow_wdata = '0;
    mode = MODE_HOLD; aux = '0; outy = '0; dv = '0; value = '0;
    rd_req = 1'b0; rd_ch = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge sysclk);
    reset  = 1'b1;
    cmp_en = 1'b1;
    check("rst_out_i", 32'(out_i), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(negedge sysclk);
    do_read(0, rdd, rds, rdn);
    check("rst_read_data", 32'(rdd), 32'd0);
    check("rst_read_sticky", 32'(rds), 32'd0);
    check("rst_read_cnt", 32'(rdn), 32'd0);

    // Merge of shadow and live under the shared mask.
    @(negedge sysclk);
    sel_mask = 9'h0F0; shadow_wr = 1'b1; shadow_ch = 3'd1; shadow_wdata = 9'h1AA;
    live = '0; live[1*W +: W] = 9'h055;
    @(negedge sysclk);
    shadow_wr = 1'b0;
    @(negedge sysclk);
    do_read(1, rdd, rds, rdn);
    check("merge_data", 32'(rdd), 32'h15A);

    // Sticky/clear race on channel 0.
    @(negedge sysclk);
    sel_mask = '1;
    @(negedge sysclk);
    do_read(0, rdd, rds, rdn);
    @(negedge sysclk);
    live[3] = ~live[3];
    do_read(0, rdd, rds, rdn);
    check("race1_sticky", 32'(rds), 32'h008);
    check("race1_cnt", 32'(rdn), 32'd1);
    live[5] = ~live[5];
    do_read(0, rdd, rds, rdn);
    check("race2_sticky", 32'(rds), 32'h020);
    check("race2_cnt", 32'(rdn), 32'd1);

    // Counter saturation on channel 2.
    do_read(2, rdd, rds, rdn);
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      live[2*W] = ~live[2*W];
    end
    do_read(2, rdd, rds, rdn);
    check("sat_cnt", 32'(rdn), 32'd3);
    check("sat_sticky", 32'(rds), 32'h001);
    do_read(2, rdd, rds, rdn);
    check("sat_after_cnt", 32'(rdn), 32'd0);
    check("sat_after_sticky", 32'(rds), 32'd0);

    // Out-of-range read leaves channel 1 untouched.
    do_read(1, rdd, rds, rdn);
    @(negedge sysclk);
    live[1*W] = ~live[1*W];
    do_read(5, rdd, rds, rdn);
    check("oor_data", 32'(rdd), 32'd0);
    check("oor_sticky", 32'(rds), 32'd0);
    check("oor_cnt", 32'(rdn), 32'd0);
    do_read(1, rdd, rds, rdn);
    check("oor_keep_sticky", 32'(rds), 32'h001);
    check("oor_keep_cnt", 32'(rdn), 32'd1);

    // Output modes.
    @(negedge sysclk);
    aux = 5'b01010; outy = 5'b00110; dv = 5'b00011; value = 5'b01111; mode = MODE_XOR;
    @(negedge sysclk);
    check("mode_xor", 32'(out_i), 32'b01100);
    mode = MODE_DV;
    @(negedge sysclk);
    check("mode_dv", 32'(out_i), 32'b00011);
    mode = MODE_HOLD; aux = 5'b10101; dv = 5'b11100; value = 5'b00000;
    repeat (2) @(negedge sysclk);
    check("mode_hold", 32'(out_i), 32'b00011);
    mode = MODE_VAL; value = 5'b01111;
    @(negedge sysclk);
    check("mode_val", 32'(out_i), 32'b01111);

    // Held request yields one read every two cycles.
    @(negedge sysclk);
    rd_ch = 3'd3; rd_req = 1'b1; acks = 0;
    repeat (6) begin
      @(negedge sysclk);
      if (rd_ack) acks++;
    end
    rd_req = 1'b0;
    check("burst_acks", 32'(acks), 32'd3);

    // Reset in the ack cycle drops rd_ack immediately.
    do_read(0, rdd, rds, rdn);
    #2 reset = 1'b0;
    #1;
    check("rst_in_ack", 32'(rd_ack), 32'd0);
    check("rst_in_ack_data", 32'(rd_data), 32'd0);
    @(negedge sysclk);
    reset = 1'b1;

    for (int i = 0; i < 600; i++) begin
      @(negedge sysclk);
      if ($urandom_range(0, 2) == 0) live[$urandom_range(0, CH*W-1)] ^= 1'b1;
      if ($urandom_range(0, 30) == 0) live = {$urandom, $urandom};
      if ($urandom_range(0, 20) == 0) sel_mask = W'($urandom);
      shadow_wr    = ($urandom_range(0, 3) == 0);
      shadow_ch    = CHW'($urandom_range(0, 7));
      shadow_wdata = W'($urandom);
      mode  = 2'($urandom);
      aux   = CH'($urandom); outy = CH'($urandom);
      dv    = CH'($urandom); value = CH'($urandom);
      rd_req = ($urandom_range(0, 2) == 0);
      rd_ch  = CHW'($urandom_range(0, 7));
    end
    @(negedge sysclk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
